// File: rtl/mem_access_unit_if.sv
// Request/response and Avalon-MM style bus bundle for the CPU memory access unit.
// master: the access unit itself; slave: control unit plus memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        busy;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_word;
  logic [31:0] resp_data;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output address, read, write, byteenable, writedata,
    output busy, resp_valid, resp_err, resp_word, resp_data
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  address, read, write, byteenable, writedata,
    input  busy, resp_valid, resp_err, resp_word, resp_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side bus master of the multicycle CPU: one fetch/load/store per request,
// lane steering for stores, size/sign extraction for loads, optional stall timeout.
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_lo;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_is_write;
  logic [31:0] r_stall_cnt;

  logic        r_read;
  logic        r_write;
  logic [31:0] r_address;
  logic [3:0]  r_byteenable;
  logic [31:0] r_writedata;
  logic        r_busy;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_word;
  logic [31:0] r_resp_data;

  logic        w_misaligned;
  logic [3:0]  w_byteenable;
  logic [31:0] w_writedata;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_data;
  logic        w_stall_last;

  // Size 3 falls into the word arms below.
  assign w_misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    w_byteenable = 4'b1111;
    case (bus.req_size)
      2'd0:    w_byteenable = 4'b0001 << bus.req_addr[1:0];
      2'd1:    w_byteenable = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      default: w_byteenable = 4'b1111;
    endcase
  end

  assign w_writedata = bus.req_wdata << {bus.req_addr[1:0], 3'b000};

  always_comb begin
    w_lane_byte = bus.readdata[7:0];
    case (r_lo)
      2'd0:    w_lane_byte = bus.readdata[7:0];
      2'd1:    w_lane_byte = bus.readdata[15:8];
      2'd2:    w_lane_byte = bus.readdata[23:16];
      default: w_lane_byte = bus.readdata[31:24];
    endcase
  end

  assign w_lane_half = r_lo[1] ? bus.readdata[31:16] : bus.readdata[15:0];

  always_comb begin
    w_load_data = bus.readdata;
    case (r_size)
      2'd0:    w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
      2'd1:    w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
      default: w_load_data = bus.readdata;
    endcase
  end

  // The current stalled cycle is the WAIT_LIMIT-th one in a row.
  assign w_stall_last = (WAIT_LIMIT != 0) && (r_stall_cnt == (32'(WAIT_LIMIT) - 32'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lo         <= 2'b00;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_is_write   <= 1'b0;
      r_stall_cnt  <= 32'd0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= 32'd0;
      r_byteenable <= 4'd0;
      r_writedata  <= 32'd0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_word  <= 32'd0;
      r_resp_data  <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_lo       <= bus.req_addr[1:0];
            r_size     <= bus.req_size;
            r_signed   <= bus.req_signed;
            r_is_write <= bus.req_write;
            r_busy     <= 1'b1;
            if (w_misaligned) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_word  <= 32'd0;
              r_resp_data  <= 32'd0;
            end else begin
              r_state      <= ST_BUS;
              r_read       <= ~bus.req_write;
              r_write      <= bus.req_write;
              r_address    <= {bus.req_addr[31:2], 2'b00};
              r_byteenable <= w_byteenable;
              r_writedata  <= w_writedata;
              r_stall_cnt  <= 32'd0;
            end
          end
        end
        ST_BUS: begin
          if (!bus.waitrequest) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_word  <= r_is_write ? 32'd0 : bus.readdata;
            r_resp_data  <= r_is_write ? 32'd0 : w_load_data;
          end else if (w_stall_last) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_word  <= 32'd0;
            r_resp_data  <= 32'd0;
          end else begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          // Any request seen here is dropped, not queued.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address    = r_address;
  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.byteenable = r_byteenable;
  assign bus.writedata  = r_writedata;
  assign bus.busy       = r_busy;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_word  = r_resp_word;
  assign bus.resp_data  = r_resp_data;

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (reset) !(r_read && r_write));
  a_strobe_stable: assert property (@(posedge clk) disable iff (reset)
    ((r_read || r_write) && bus.waitrequest && !w_stall_last) |=>
      ($stable(r_address) && $stable(r_byteenable) && $stable(r_writedata)));

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with WAIT_LIMIT=4.
module tb_mem_access_unit;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
    logic [31:0] data;
  } resp_t;

  logic  clk = 1'b0;
  logic  reset;
  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus_if ();

  mem_access_unit #(
    .WAIT_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'd0) begin
      case (lo)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (size == 2'd1) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] w, input logic [1:0] lo);
    case (lo)
      2'd0: return w;
      2'd1: return {w[23:0], 8'h00};
      2'd2: return {w[15:0], 16'h0000};
      default: return {w[7:0], 24'h000000};
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] lo, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    if (size == 2'd0) return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
    if (size == 2'd1) return (sgn && h[15]) ? {16'hFFFF, h} : {16'h0, h};
    return rd;
  endfunction

  // Issues one request, plays the memory with `stalls` wait cycles, and checks the result.
  // Returns at the falling edge of the cycle in which resp_valid was seen.
  task automatic do_access(input string name, input logic wr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int stalls);
    logic  mis;
    int    exp_strobes;
    int    strobes;
    bit    done;
    resp_t e;
    resp_t got;
    mis = model_mis(size, addr);
    if (mis) exp_strobes = 0;
    else if (stalls >= LIMIT) exp_strobes = LIMIT;
    else exp_strobes = stalls + 1;
    e.err  = mis || (stalls >= LIMIT);
    e.word = (e.err || wr) ? 32'd0 : rdata;
    e.data = (e.err || wr) ? 32'd0 : model_load(size, sgn, addr[1:0], rdata);
    strobes = 0;
    done = 0;
    @(negedge clk);
    bus_if.req_valid   = 1'b1;
    bus_if.req_write   = wr;
    bus_if.req_size    = size;
    bus_if.req_signed  = sgn;
    bus_if.req_addr    = addr;
    bus_if.req_wdata   = wdata;
    bus_if.readdata    = rdata;
    bus_if.waitrequest = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) begin
        n_checks++;
        if (bus_if.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy_after_accept: got %b want 1", name, bus_if.busy);
        end
      end
      if (bus_if.read || bus_if.write) begin
        strobes++;
        n_checks++;
        if ({bus_if.read, bus_if.write, bus_if.address, bus_if.byteenable} !==
            {~wr, wr, {addr[31:2], 2'b00}, model_be(size, addr[1:0])}) begin
          n_fail++;
          $display("FAIL %s strobe_cycle%0d: got rd=%b wr=%b addr=%h be=%b want rd=%b wr=%b addr=%h be=%b",
                   name, strobes, bus_if.read, bus_if.write, bus_if.address, bus_if.byteenable,
                   ~wr, wr, {addr[31:2], 2'b00}, model_be(size, addr[1:0]));
        end
        if (wr) begin
          n_checks++;
          if (bus_if.writedata !== model_wd(wdata, addr[1:0])) begin
            n_fail++;
            $display("FAIL %s writedata: got %h want %h", name, bus_if.writedata,
                     model_wd(wdata, addr[1:0]));
          end
        end
      end
      bus_if.waitrequest = (strobes <= stalls);
      if (bus_if.resp_valid === 1'b1) begin
        done = 1;
        n_checks++;
        if (cyc != exp_strobes + 1 || strobes != exp_strobes) begin
          n_fail++;
          $display("FAIL %s latency: got resp at cycle %0d after %0d strobes want cycle %0d after %0d",
                   name, cyc, strobes, exp_strobes + 1, exp_strobes);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s scoreboard: got unexpected response want none", name);
        end else begin
          got = exp_q.pop_front();
          if ({bus_if.resp_err, bus_if.resp_word, bus_if.resp_data} !== got) begin
            n_fail++;
            $display("FAIL %s response: got err=%b word=%h data=%h want err=%b word=%h data=%h",
                     name, bus_if.resp_err, bus_if.resp_word, bus_if.resp_data,
                     got.err, got.word, got.data);
          end
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s resp_timeout: got no resp_valid want one within 40 cycles", name);
      void'(exp_q.pop_front());
    end
    bus_if.waitrequest = 1'b0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    n_checks++;
    if ({bus_if.busy, bus_if.resp_valid, bus_if.read, bus_if.write} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle: got busy=%b rv=%b rd=%b wr=%b want all 0", name, bus_if.busy,
               bus_if.resp_valid, bus_if.read, bus_if.write);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.req_valid   = 1'b0;
    bus_if.req_write   = 1'b0;
    bus_if.req_size    = 2'd0;
    bus_if.req_signed  = 1'b0;
    bus_if.req_addr    = 32'd0;
    bus_if.req_wdata   = 32'd0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata    = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_if.read, bus_if.write, bus_if.busy, bus_if.resp_valid, bus_if.resp_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b busy=%b rv=%b err=%b want all 0", bus_if.read,
               bus_if.write, bus_if.busy, bus_if.resp_valid, bus_if.resp_err);
    end
    n_checks++;
    if ({bus_if.address, bus_if.byteenable, bus_if.writedata, bus_if.resp_word,
         bus_if.resp_data} !== 132'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h be=%b wd=%h word=%h data=%h want all 0",
               bus_if.address, bus_if.byteenable, bus_if.writedata, bus_if.resp_word,
               bus_if.resp_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_loads;
    do_access("word_read", 1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    check_idle("word_read");
    do_access("sbyte_stall", 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3);
    do_access("ubyte_stall", 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3);
    do_access("shalf_hi", 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1);
    do_access("uhalf_lo", 1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0, 32'h8001_F00D, 0);
    do_access("size3_word", 1'b0, 2'd3, 1'b1, 32'h0000_0010, 32'h0, 32'h1234_5678, 2);
  endtask

  task automatic test_stores;
    do_access("half_store", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h5555_5555, 0);
    do_access("byte_store", 1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00A5, 32'h0, 2);
    do_access("word_store", 1'b1, 2'd2, 1'b0, 32'h0000_2008, 32'hCAFE_F00D, 32'h0, 0);
  endtask

  task automatic test_misaligned;
    do_access("mis_word", 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'hFFFF_FFFF, 0);
    do_access("mis_half_store", 1'b1, 2'd1, 1'b0, 32'h0000_3003, 32'h1111, 32'h0, 0);
    check_idle("misaligned");
  endtask

  task automatic test_timeout;
    do_access("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h7777_7777, 100);
    check_idle("timeout");
    do_access("after_timeout", 1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'h0, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_resp_ignore;
    do_access("pre_ignore", 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h2468_ACE0, 0);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_size  = 2'd2;
    bus_if.req_addr  = 32'h0000_5004;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    n_checks++;
    if ({bus_if.busy, bus_if.write, bus_if.read} !== 3'b000) begin
      n_fail++;
      $display("FAIL resp_ignore: got busy=%b wr=%b rd=%b want 0 0 0", bus_if.busy,
               bus_if.write, bus_if.read);
    end
    bus_if.waitrequest = 1'b1;
    check_idle("resp_ignore");
    bus_if.waitrequest = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_access("b2b_a", 1'b0, 2'd0, 1'b1, 32'h0000_6002, 32'h0, 32'h0045_0000, 0);
    do_access("b2b_b", 1'b1, 2'd0, 1'b0, 32'h0000_6003, 32'h0000_007E, 32'h0, 0);
    do_access("b2b_c", 1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'h0, 32'h0000_9ABC, 0);
  endtask

  task automatic test_reset_mid_bus;
    bit ok_pre;
    @(negedge clk);
    bus_if.req_valid   = 1'b1;
    bus_if.req_write   = 1'b0;
    bus_if.req_size    = 2'd2;
    bus_if.req_addr    = 32'h0000_7000;
    bus_if.waitrequest = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    ok_pre = bus_if.read;
    @(negedge clk);
    n_checks++;
    if (!(ok_pre && bus_if.read === 1'b1)) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got read=%b,%b want 1,1", ok_pre, bus_if.read);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_if.read, bus_if.busy, bus_if.resp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_bus: got rd=%b busy=%b rv=%b want 0 0 0", bus_if.read,
               bus_if.busy, bus_if.resp_valid);
    end
    reset = 1'b0;
    bus_if.waitrequest = 1'b0;
    check_idle("reset_mid_after1");
    check_idle("reset_mid_after2");
    do_access("after_reset", 1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'h0, 32'h1357_9BDF, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_resp_ignore();
    test_back_to_back();
    test_reset_mid_bus();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
